// File: rtl/prog_sequencer.sv
// Program sequencer: replays a small program memory onto a processor DIN bus.
// Ports: clk/rstn, start/abort/prog_len control, wr_* memory load, done in;
// din/run/busy/finished/err/pc out. Optional macro: SEQ_TIMEOUT_EN.
module prog_sequencer #(
  parameter int N     = 32,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic         abort,
  input  logic [4:0]   prog_len,
  input  logic         wr_en,
  input  logic [3:0]   wr_addr,
  input  logic [N-1:0] wr_data,
  input  logic         done,
  output logic [N-1:0] din,
  output logic         run,
  output logic         busy,
  output logic         finished,
  output logic         err,
  output logic [4:0]   pc
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [4:0] LEN_MAX = 5'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_IMM,
    S_WAIT,
    S_END
  } state_t;

  state_t       state, state_d;
  logic [N-1:0] mem [DEPTH];
  logic [4:0]   len, len_d, pc_d;
  logic         err_d, run_d;
  logic [N-1:0] din_d, fetch;

`ifdef SEQ_TIMEOUT_EN
  logic [3:0] tcnt, tcnt_d;
`endif

  function automatic logic is_mvi(input logic [N-1:0] w);
    return w[8:6] == 3'b001;
  endfunction

  always_ff @(posedge clk) begin
    if (wr_en && state == S_IDLE)
      mem[wr_addr] <= wr_data;
  end

  always_comb begin
    state_d = state;
    pc_d    = pc;
    len_d   = len;
    err_d   = err;
`ifdef SEQ_TIMEOUT_EN
    tcnt_d  = tcnt;
`endif
    unique case (state)
      S_IDLE: begin
        if (start && prog_len != 5'd0) begin
          state_d = S_ISSUE;
          pc_d    = 5'd0;
          err_d   = 1'b0;
          len_d   = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
        end
      end
      S_ISSUE: begin
        pc_d = pc + 5'd1;
        // an mvi in the final slot has no immediate word to follow it
        if (is_mvi(din) && pc == len - 5'd1) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (is_mvi(din)) begin
          state_d = S_IMM;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_IMM: begin
        pc_d = pc + 5'd1;
        if (done)
          state_d = (pc + 5'd1 >= len) ? S_END : S_ISSUE;
        else
          state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done) begin
          state_d = (pc >= len) ? S_END : S_ISSUE;
`ifdef SEQ_TIMEOUT_EN
        end else if (tcnt == 4'hF) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          tcnt_d = tcnt + 4'd1;
`endif
        end
      end
      S_END: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
`ifdef SEQ_TIMEOUT_EN
    if (state_d == S_WAIT && state != S_WAIT)
      tcnt_d = 4'd0;
`endif
    if (abort) begin
      state_d = S_IDLE;
      pc_d    = pc;
      len_d   = len;
      err_d   = err;
    end
  end

  // outputs are registered, so they are derived from the next state
  always_comb begin
    fetch = mem[pc_d[AW-1:0]];
    din_d = '0;
    run_d = 1'b0;
    if (state_d == S_ISSUE || state_d == S_IMM)
      din_d = fetch;
    else if (state_d == S_WAIT)
      din_d = din;
    if (state_d == S_ISSUE)
      run_d = !(is_mvi(fetch) && pc_d == len_d - 5'd1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      pc       <= 5'd0;
      len      <= 5'd0;
      err      <= 1'b0;
      din      <= '0;
      run      <= 1'b0;
      busy     <= 1'b0;
      finished <= 1'b0;
    end else begin
      state    <= state_d;
      pc       <= pc_d;
      len      <= len_d;
      err      <= err_d;
      din      <= din_d;
      run      <= run_d;
      busy     <= (state_d != S_IDLE);
      finished <= (state_d == S_END);
    end
  end

`ifdef SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      tcnt <= 4'd0;
    else
      tcnt <= tcnt_d;
  end
`endif

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 SHALL have parameter N, default 32, meaning data/instruction word width.
REQ-002 SHALL have parameter DEPTH, default 16, meaning program memory entries.
REQ-003 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-004 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  begin program execution from word 0.
REQ-006 SHALL have port abort  input  1  synchronous return to IDLE.
REQ-007 SHALL have port prog_len  input  5  number of words to execute, sampled on start.
REQ-008 SHALL have port wr_en  input  1  program memory write strobe.
REQ-009 SHALL have port wr_addr  input  4  program memory write address.
REQ-010 SHALL have port wr_data  input  N  program memory write data.
REQ-011 SHALL have port done  input  1  processor instruction-complete pulse.
REQ-012 SHALL have port din  output  N  word driven to processor DIN bus.
REQ-013 SHALL have port run  output  1  one-cycle instruction-issue strobe.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port finished  output  1  one-cycle pulse on normal program completion.
REQ-016 SHALL have port err  output  1  sticky error flag.
REQ-017 SHALL have port pc  output  5  index of next word to fetch.

Function
REQ-018 SHALL implement states IDLE, ISSUE, IMM, WAIT, END; all outputs registered.
REQ-019 SHALL write mem[wr_addr] <= wr_data on wr_en only in IDLE; writes in other states ignored.
REQ-020 IDLE: start=1 and prog_len!=0 -> ISSUE, pc<=0, err<=0, len<=min(prog_len,DEPTH); start with prog_len=0 -> stay IDLE, no run.
REQ-021 ISSUE: din=mem[pc], run=1 for exactly this cycle, pc<=pc+1; opcode din[8:6]==3'b001 (mvi) -> IMM, else -> WAIT.
REQ-022 ISSUE with mvi at pc==len-1 (no immediate word): run=0, err<=1 -> IDLE.
REQ-023 IMM: din=mem[pc] (immediate), run=0, pc<=pc+1; if done=1 this cycle -> END when pc+1>=len else ISSUE; else -> WAIT.
REQ-024 WAIT: din holds last word, run=0; done=1 -> END when pc>=len else ISSUE; done=0 -> stay.
REQ-025 done in IDLE, ISSUE or END SHALL be ignored.
REQ-026 END: finished=1 for one cycle -> IDLE.
REQ-027 abort=1 in any state -> IDLE next cycle, run=0, din=0, pc held, err unchanged; abort wins over simultaneous done or start.
REQ-028 IDLE: din=0, run=0, busy=0.
REQ-029 pc SHALL be 5 bits so len=16 terminates at pc=16 without wrap.

Reset
REQ-030 rstn=0 SHALL asynchronously force state=IDLE, din=0, run=0, busy=0, finished=0, err=0, pc=0, len=0, timeout counter=0.
REQ-031 Program memory contents SHALL be unaffected by reset.
REQ-032 Reset mid-program SHALL abandon execution with no further run pulse.

Configuration
REQ-033 Macro SEQ_TIMEOUT_EN defined: 4-bit counter clears on entry to WAIT, increments each WAIT cycle without done; 16 consecutive cycles -> err<=1, IDLE, no finished.
REQ-034 Macro SEQ_TIMEOUT_EN undefined: no counter; WAIT persists indefinitely until done or abort.

Verification
REQ-035 mem={mv(0x001),add(0x081)}, len=2, done 1 cycle after each run -> run pulses at cycles 1 and 3, finished at cycle 5, err=0.
REQ-036 mem={mvi(0x040),0x0000ABCD}, len=2, done in IMM cycle -> din=0x040 with run, next cycle din=0x0000ABCD, run=0, END next, finished=1.
REQ-037 mem[0]=mvi, len=1, start -> no run pulse, err=1, busy=0 after 2 cycles.
REQ-038 abort and done asserted together in WAIT -> IDLE, run=0, finished=0, pc unchanged.
REQ-039 SEQ_TIMEOUT_EN defined, done never asserted after run -> err=1 and IDLE 16 cycles after WAIT entry; undefined -> busy=1 after 100 cycles.
REQ-040 wr_en during WAIT to addr 1 -> mem[1] unchanged when re-read via subsequent run; rstn=0 mid-WAIT -> all outputs zero immediately.
